// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Request/response bundle for the bit-serial subtractor.
//   master : drives start, a, b; observes busy, done, diff, borrow
//   slave  : the subtractor itself
//   start  - begin a subtraction (accepted when the block is not shifting)
//   a, b   - minuend / subtrahend, sampled only on an accepted start
//   busy   - a subtraction is shifting
//   done   - one-cycle pulse, diff/borrow hold the result
//   diff   - (a - b) mod 2^WIDTH
//   borrow - 1 iff a < b
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: one bit per clock, LSB first.
//   A start accepted in IDLE or DONE loads the operands; WIDTH SHIFT cycles
//   later the block spends one cycle in DONE with done=1 and the result on
//   diff/borrow. start held high chains operations with no idle gap.
// Ports
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, wins over start
//   bus  - serial_subtractor_if.slave (start/a/b in, busy/done/diff/borrow out)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic             load;
    logic             last;
    logic             busy_c, done_c;

    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             bin;
    logic             borrow_q;
    logic [CW-1:0]    cnt;

    logic             d, bout;

    // One full-subtractor slice on the current LSBs.
    assign d    = a_sr[0] ^ b_sr[0] ^ bin;
    assign bout = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bin);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The diff shift register is the visible diff output: it holds the
    // previous result until the first SHIFT edge, shows partial contents while
    // shifting, and is complete after the final SHIFT edge. borrow is only
    // published at that final edge, so it never shows an intermediate value.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            bin      <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            bin  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= {d, diff_sr[WIDTH-1:1]};
            bin     <= bout;
            cnt     <= cnt + CW'(1);
            if (last) borrow_q <= bout;
        end
    end

    // All outputs come from flops or state decode only.
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.diff   = diff_sr;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Randomized + directed bench for serial_subtractor (WIDTH=8). The driver
//   tracks acceptance with a simple "cycles until free" timing model and pushes
//   the arithmetic result (a-b mod 256, a<b) plus the expected done cycle into
//   a queue; an independent monitor pops and checks on every done pulse.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_left = 0;
    int   nacc = 0;
    exp_t q[$];

    serial_subtractor_if #(.WIDTH(W)) bus();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge; inputs were set before the call. Updates the model.
    task automatic step();
        bit           acc;
        logic [W-1:0] ea, eb;
        exp_t         e;
        acc = bus.start && !rst && (m_left == 0);
        ea  = bus.a;
        eb  = bus.b;
        @(posedge clk);
        #1;
        if (rst) begin
            m_left = 0;
            q.delete();
        end else if (acc) begin
            m_left   = W;
            nacc++;
            e.diff   = W'((int'(ea) - int'(eb)) & ((1 << W) - 1));
            e.borrow = (ea < eb);
            e.cyc    = cyc + W;
            q.push_back(e);
        end else if (m_left > 0) begin
            m_left--;
        end
        chk("busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        step();
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        repeat (W + 2) step();
    endtask

    // Monitor: independent of the stimulus, reacts to done only.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy && bus.done) begin
            miscompares++;
            $display("FAIL busy_and_done both high at cycle %0d", cyc);
        end
        if (bus.done) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("diff", {24'b0, bus.diff}, {24'b0, e.diff});
                chk("borrow", {31'b0, bus.borrow}, {31'b0, e.borrow});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 8'd77;
        bus.b = 8'd12;
        step();
        step();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_diff", {24'b0, bus.diff}, 32'd0);
        chk("rst_borrow", {31'b0, bus.borrow}, 32'd0);
        rst = 1'b0;
        bus.start = 1'b0;

        // Directed results, first one right after reset release.
        run_op(8'd200, 8'd55);
        run_op(8'd5, 8'd10);
        run_op(8'd0, 8'd0);
        run_op(8'h00, 8'hFF);

        // Second start in SHIFT must be ignored.
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd55;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
        step();
        bus.start = 1'b0;
        repeat (W + 2) step();

        // Reset mid-SHIFT aborts; no done may follow.
        bus.start = 1'b1; bus.a = 8'd123; bus.b = 8'd45;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_diff", {24'b0, bus.diff}, 32'd0);
        chk("abort_borrow", {31'b0, bus.borrow}, 32'd0);
        rst = 1'b0;
        repeat (10) step();

        // Back-to-back with start held: (9,3) then (3,9).
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd3;
        step();
        bus.a = 8'd3; bus.b = 8'd9;
        repeat (W + 1) step();
        bus.start = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0;
        repeat (W + 2) step();

        // Random sweep: random start density, operands changing every cycle.
        nacc = 0;
        while (nacc < 3000) begin
            bus.start = ($urandom_range(0, 3) != 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            step();
        end
        bus.start = 1'b0;
        repeat (W + 3) step();

        chk("pending_results", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
